// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// The execute-stage decoder maps aluop onto the MD_* codes below.
package ex_muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Divide ops have the upper op bit set.
  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops have the lower op bit clear.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep or restore.
module ex_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Trial subtraction; a borrow into the top bit means the divisor did not fit.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[DATA_W];
    rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit beside the execute stage.
// Operands are reduced to magnitudes at accept, iterated in CALC, and the
// sign is restored in a two-cycle FIX (negate, then publish to hi/lo).
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MUL_K  = 1   // 1, 2 or 4; must divide DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              div_zero_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int HI_W  = DATA_W + MUL_K + 1;
  localparam int ACC_W = HI_W + DATA_W;
  localparam logic [CNT_W-1:0] MUL_ITER = CNT_W'(DATA_W / MUL_K);
  localparam logic [CNT_W-1:0] DIV_ITER = CNT_W'(DATA_W);

  md_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W:0]   mcand;
  logic              is_div;
  logic              neg_res;
  logic              neg_rem;
  logic              dz_pend;
  logic              fix_phase;

  logic              accept;
  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;

  logic [MUL_K-1:0]  mul_bits;
  logic [HI_W-1:0]   mul_pp;
  logic [HI_W-1:0]   mul_sum;
  logic [ACC_W-1:0]  mul_next;

  logic [DATA_W-1:0] div_rem_out;
  logic              div_q;
  logic [ACC_W-1:0]  div_next;

  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] fixed;

  // Accept decision and operand magnitudes; a flush always beats a start.
  always_comb begin
    accept = start_i && !flush_i && (state == ST_IDLE || state == ST_DONE);
    a_neg  = md_is_signed(op_i) && a_i[DATA_W-1];
    b_neg  = md_is_signed(op_i) && b_i[DATA_W-1];
    mag_a  = a_neg ? -a_i : a_i;
    mag_b  = b_neg ? -b_i : b_i;
  end

  // Shift-add multiply: add MUL_K partial products to the upper half, then shift right.
  always_comb begin
    mul_bits = acc[MUL_K-1:0];
    mul_pp   = '0;
    for (int i = 0; i < MUL_K; i++) begin
      if (mul_bits[i]) begin
        mul_pp = mul_pp + (HI_W'(mcand) << i);
      end
    end
    mul_sum  = acc[ACC_W-1:DATA_W] + mul_pp;
    mul_next = {mul_sum, acc[DATA_W-1:0]} >> MUL_K;
  end

  ex_div_step #(
    .DATA_W(DATA_W)
  ) u_div_step (
    .rem_in      (acc[2*DATA_W-1:DATA_W]),
    .dividend_bit(acc[DATA_W-1]),
    .divisor     (mcand[DATA_W-1:0]),
    .rem_out     (div_rem_out),
    .q_bit       (div_q)
  );

  // Divide keeps the remainder in the upper half and shifts quotient bits into the lower half.
  always_comb begin
    div_next = {{(MUL_K + 1){1'b0}}, div_rem_out, acc[DATA_W-2:0], div_q};
  end

  // Sign correction: negate product/quotient on differing signs, remainder follows the dividend.
  always_comb begin
    res_hi = acc[2*DATA_W-1:DATA_W];
    res_lo = acc[DATA_W-1:0];
    prod   = acc[2*DATA_W-1:0];
    if (is_div) begin
      fixed = {(neg_rem ? -res_hi : res_hi), (neg_res ? -res_lo : res_lo)};
    end else begin
      fixed = neg_res ? -prod : prod;
    end
  end

  // Control FSM with registered busy/done and the result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      is_div     <= 1'b0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      dz_pend    <= 1'b0;
      fix_phase  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            busy_o    <= 1'b1;
            fix_phase <= 1'b0;
            is_div    <= md_is_div(op_i);
            if (md_is_div(op_i) && b_i == '0) begin
              // Divide by zero: raw dividend and all-ones go straight to FIX untouched.
              state   <= ST_FIX;
              dz_pend <= 1'b1;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              mcand   <= '0;
              acc     <= {{(MUL_K + 1){1'b0}}, a_i, {DATA_W{1'b1}}};
            end else begin
              state   <= ST_CALC;
              dz_pend <= 1'b0;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= md_is_div(op_i) && a_neg;
              if (md_is_div(op_i)) begin
                cnt   <= DIV_ITER;
                mcand <= {1'b0, mag_b};
                acc   <= {{(HI_W){1'b0}}, mag_a};
              end else begin
                cnt   <= MUL_ITER;
                mcand <= {1'b0, mag_a};
                acc   <= {{(HI_W){1'b0}}, mag_b};
              end
            end
          end else begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          if (flush_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (!fix_phase) begin
            acc[2*DATA_W-1:0] <= fixed;
            fix_phase         <= 1'b1;
          end else begin
            hi_o       <= acc[2*DATA_W-1:DATA_W];
            lo_o       <= acc[DATA_W-1:0];
            div_zero_o <= dz_pend;
            done_o     <= 1'b1;
            busy_o     <= 1'b0;
            state      <= ST_DONE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: one instance with MUL_K=1 and one
// with MUL_K=4, each with a scoreboard queue filled at launch and drained on done_o.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1;
  logic        start4;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;

  logic        busy1, done1, dz1;
  logic [31:0] hi1, lo1;
  logic        busy4, done4, dz4;
  logic [31:0] hi4, lo4;

  exp_t q1[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // 10-unit clock period
  always #5 clk = ~clk;

  ex_muldiv_unit #(.DATA_W(32), .MUL_K(1)) dut (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy1), .done_o(done1), .hi_o(hi1), .lo_o(lo1),
    .div_zero_o(dz1)
  );

  ex_muldiv_unit #(.DATA_W(32), .MUL_K(4)) dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy4), .done_o(done4), .hi_o(hi4), .lo_o(lo4),
    .div_zero_o(dz4)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of the four operations, written from the arithmetic definition
  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    r.dz = 1'b0;
    r.hi = '0;
    r.lo = '0;
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      MD_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          r.hi = a;
          r.lo = '1;
          r.dz = 1'b1;
        end else if (op == MD_DIV) begin
          r.lo = 32'(sa / sb);
          r.hi = 32'(sa % sb);
        end else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
    endcase
    return r;
  endfunction

  // Scoreboard drain for the MUL_K=1 instance
  always begin : mon1
    exp_t e;
    @(posedge clk);
    #1;
    if (done1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_unexpected_done", 64'(done1), 64'(0));
      end else begin
        e = q1.pop_front();
        checkOutput("dut1_hi", 64'(hi1), 64'(e.hi));
        checkOutput("dut1_lo", 64'(lo1), 64'(e.lo));
        checkOutput("dut1_div_zero", 64'(dz1), 64'(e.dz));
      end
    end
  end

  // Scoreboard drain for the MUL_K=4 instance
  always begin : mon4
    exp_t e;
    @(posedge clk);
    #1;
    if (done4) begin
      if (q4.size() == 0) begin
        checkOutput("dut4_unexpected_done", 64'(done4), 64'(0));
      end else begin
        e = q4.pop_front();
        checkOutput("dut4_hi", 64'(hi4), 64'(e.hi));
        checkOutput("dut4_lo", 64'(lo4), 64'(e.lo));
        checkOutput("dut4_div_zero", 64'(dz4), 64'(e.dz));
      end
    end
  end

  // Drive one start pulse (called #1 after an edge); optionally record the expected result
  task automatic launch(input int sel, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push);
    op_i = op;
    a_i  = a;
    b_i  = b;
    if (sel == 4) start4 = 1'b1;
    else          start1 = 1'b1;
    if (push) begin
      if (sel == 4) q4.push_back(model(op, a, b));
      else          q1.push_back(model(op, a, b));
    end
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  // Count edges until done_o, bounded; a timeout shows up as latency 0
  task automatic waitDone(input int sel, input string tag, input int exp_lat);
    int  lat;
    bit  seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk);
      #1;
      if ((sel == 4) ? done4 : done1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    checkOutput(tag, 64'(lat), 64'(exp_lat));
  endtask

  task automatic applyStimulus(input int sel, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int exp_lat, input string tag);
    launch(sel, op, a, b, 1'b1);
    waitDone(sel, tag, exp_lat);
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst     = 1'b1;
    start1  = 1'b0;
    start4  = 1'b0;
    flush_i = 1'b0;
    op_i    = '0;
    a_i     = '0;
    b_i     = '0;
    stepCycles(3);
    checkOutput("rst_busy", 64'(busy1), 64'(0));
    checkOutput("rst_done", 64'(done1), 64'(0));
    checkOutput("rst_hi", 64'(hi1), 64'(0));
    checkOutput("rst_lo", 64'(lo1), 64'(0));
    checkOutput("rst_dz", 64'(dz1), 64'(0));
    checkOutput("rst_busy4", 64'(busy4), 64'(0));
    rst = 1'b0;
    stepCycles(1);

    // Multiplies, including the -2^31 magnitude corner
    applyStimulus(1, MD_MULT, 32'd7, 32'hFFFFFFFD, 34, "lat_mult");
    applyStimulus(1, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "lat_multu");
    applyStimulus(4, MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 10, "lat_multu_k4");
    applyStimulus(1, MD_MULT, 32'h80000000, 32'h80000000, 34, "lat_mult_min_min");
    applyStimulus(1, MD_MULT, 32'h80000000, 32'hFFFFFFFF, 34, "lat_mult_min_neg1");
    applyStimulus(4, MD_MULT, 32'd7, 32'hFFFFFFFD, 10, "lat_mult_k4");

    // Divides: signed/unsigned, overflow corner, remainder sign
    applyStimulus(1, MD_DIV, 32'hFFFFFFF9, 32'd2, 34, "lat_div");
    applyStimulus(1, MD_DIVU, 32'd100, 32'd7, 34, "lat_divu");
    applyStimulus(1, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 34, "lat_div_overflow");
    applyStimulus(1, MD_DIV, 32'd7, 32'hFFFFFFFE, 34, "lat_div_neg_divisor");
    applyStimulus(4, MD_DIVU, 32'hFFFFFFFF, 32'd1, 34, "lat_divu_k4");

    // Divide by zero skips CALC
    applyStimulus(1, MD_DIV, 32'd5, 32'd0, 2, "lat_div_zero");
    applyStimulus(4, MD_DIVU, 32'hCAFEF00D, 32'd0, 2, "lat_divu_zero_k4");

    // Start while busy is ignored; start in the DONE cycle is accepted
    launch(1, MD_MULT, 32'd12345, 32'hFFFF0000, 1'b1);
    stepCycles(4);
    launch(1, MD_MULTU, 32'h0000DEAD, 32'h0000BEEF, 1'b0);
    checkOutput("busy_during_ignored_start", 64'(busy1), 64'(1));
    waitDone(1, "lat_after_ignored_start", 29);
    launch(1, MD_DIVU, 32'd100, 32'd7, 1'b1);
    checkOutput("busy_after_done_start", 64'(busy1), 64'(1));
    waitDone(1, "lat_back_to_back", 34);
    stepCycles(1);

    // Flush together with start in IDLE: start dropped
    op_i    = MD_DIVU;
    a_i     = 32'd9;
    b_i     = 32'd3;
    start1  = 1'b1;
    flush_i = 1'b1;
    stepCycles(1);
    start1  = 1'b0;
    flush_i = 1'b0;
    checkOutput("flush_start_busy", 64'(busy1), 64'(0));

    // Flush at CALC cycle 10: abort, previous result (100/7) retained
    launch(1, MD_DIVU, 32'd1000, 32'd3, 1'b0);
    stepCycles(9);
    flush_i = 1'b1;
    stepCycles(1);
    flush_i = 1'b0;
    checkOutput("flush_calc_busy", 64'(busy1), 64'(0));
    checkOutput("flush_calc_done", 64'(done1), 64'(0));
    checkOutput("flush_calc_hi", 64'(hi1), 64'(2));
    checkOutput("flush_calc_lo", 64'(lo1), 64'(14));
    stepCycles(40);
    checkOutput("flush_calc_lo_later", 64'(lo1), 64'(14));

    // Flush in FIX (divide-by-zero path): div_zero_o must not appear
    launch(1, MD_DIV, 32'd5, 32'd0, 1'b0);
    flush_i = 1'b1;
    stepCycles(1);
    flush_i = 1'b0;
    checkOutput("flush_fix_busy", 64'(busy1), 64'(0));
    stepCycles(3);
    checkOutput("flush_fix_dz", 64'(dz1), 64'(0));
    checkOutput("flush_fix_hi", 64'(hi1), 64'(2));

    // Flush during DONE leaves the fresh result alone
    applyStimulus(1, MD_MULTU, 32'd3, 32'd5, 34, "lat_multu_small");
    flush_i = 1'b1;
    stepCycles(1);
    flush_i = 1'b0;
    checkOutput("flush_done_lo", 64'(lo1), 64'(15));
    checkOutput("flush_done_hi", 64'(hi1), 64'(0));

    // Reset at CALC cycle 10 clears everything
    launch(1, MD_MULT, 32'd3, 32'd5, 1'b0);
    stepCycles(9);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("midrst_busy", 64'(busy1), 64'(0));
    checkOutput("midrst_done", 64'(done1), 64'(0));
    checkOutput("midrst_hi", 64'(hi1), 64'(0));
    checkOutput("midrst_lo", 64'(lo1), 64'(0));
    checkOutput("midrst_dz", 64'(dz1), 64'(0));
    rst = 1'b0;
    stepCycles(1);

    // Random mix on both instances
    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : $urandom;
      applyStimulus(1, rop, ra, rb, (rop[1] && rb == 32'd0) ? 2 : 34, "lat_rand_k1");
      applyStimulus(4, rop, ra, rb, (rop[1] && rb == 32'd0) ? 2 : (rop[1] ? 34 : 10), "lat_rand_k4");
    end

    stepCycles(3);
    checkOutput("scoreboard1_drained", 64'(q1.size()), 64'(0));
    checkOutput("scoreboard4_drained", 64'(q4.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
